// File: rtl/mem_pkg.sv
// Shared memory-interface definitions for the core's data-memory path.
package mem_pkg;

  // Width of the load/store funct3 field, shared with the decoder.
  localparam int FUNCT3_W  = 3;

  // Lane geometry of a data word.
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  // Unshifted byte-enable encodings produced by the core.
  localparam logic [NUM_LANES-1:0] BE_BYTE = 4'b0001;
  localparam logic [NUM_LANES-1:0] BE_HALF = 4'b0011;
  localparam logic [NUM_LANES-1:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_e;

  // Request fields captured in IDLE; the address travels separately
  // because its width is a per-instance parameter.
  typedef struct packed {
    logic                             wen;
    logic [NUM_LANES-1:0]             be;
    logic [NUM_LANES-1:0][VEC_W-1:0]  data;
  } mem_req_t;

  function automatic logic be_legal(input logic [NUM_LANES-1:0] be);
    return (be == BE_BYTE) || (be == BE_HALF) || (be == BE_WORD);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment: realigns the unshifted byte mask and store data to
// the address offset, shifts read data down to lane 0, and flags illegal
// or misaligned requests.
module dmem_lane_align
  import mem_pkg::*;
(
  input  logic [NUM_LANES-1:0]       be,
  input  logic [1:0]                 off,
  input  logic [NUM_LANES*VEC_W-1:0] wdata_in,
  input  logic [NUM_LANES*VEC_W-1:0] rword,
  output logic [NUM_LANES-1:0]       mask,
  output logic [NUM_LANES*VEC_W-1:0] wdata,
  output logic [NUM_LANES*VEC_W-1:0] rdata,
  output logic                       err
);

  logic [4:0] bit_off;

  assign bit_off = {off, 3'b000};

  // Shift masks and data by the byte offset; upper read lanes fill with zero.
  always_comb begin
    mask  = be << off;
    wdata = wdata_in << bit_off;
    rdata = rword >> bit_off;
  end

  // Halfwords need an even offset, words need offset zero.
  always_comb begin
    err = 1'b0;
    if (!be_legal(be))                    err = 1'b1;
    else if ((be == BE_HALF) && off[0])   err = 1'b1;
    else if ((be == BE_WORD) && off != 0) err = 1'b1;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY
// cycles, then issues a one-cycle READY with lane-aligned data or an error.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  D_MEM_CSN,
  input  logic                  D_MEM_WEN,
  input  logic [3:0]            D_MEM_BE,
  input  logic [ADDR_WIDTH-1:0] D_MEM_ADDR,
  input  logic [31:0]           D_MEM_DOUT,
  output logic [31:0]           D_MEM_DI,
  output logic                  D_MEM_READY,
  output logic                  D_MEM_ERR,
  output logic                  D_MEM_BUSY
);

  localparam int         DEPTH    = 1 << (ADDR_WIDTH - 2);
  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  mem_state_e            state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic                  capture;
  mem_req_t              req_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic [NUM_LANES-1:0]       mask;
  logic [NUM_LANES*VEC_W-1:0] wdata, rdata, rword;
  logic                       err;
  logic [ADDR_WIDTH-3:0]      word_idx;
  logic                       do_write;

  // Word array; intentionally not reset. Simulation may preload it through
  // a hierarchical reference to mem.
  logic [31:0] mem [DEPTH];

  // State, wait counter and captured request.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state  <= IDLE;
      cnt    <= '0;
      req_q  <= '0;
      addr_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (capture) begin
        req_q.wen  <= D_MEM_WEN;
        req_q.be   <= D_MEM_BE;
        req_q.data <= D_MEM_DOUT;
        addr_q     <= D_MEM_ADDR;
      end
    end
  end

  // Next state: CSN is only looked at in IDLE; WAIT counts down to zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (!D_MEM_CSN) begin
          capture = 1'b1;
          if (LATENCY == 0) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign word_idx = addr_q[ADDR_WIDTH-1:2];
  assign rword    = mem[word_idx];

  dmem_lane_align u_align (
    .be       (req_q.be),
    .off      (addr_q[1:0]),
    .wdata_in (req_q.data),
    .rword    (rword),
    .mask     (mask),
    .wdata    (wdata),
    .rdata    (rdata),
    .err      (err)
  );

  // A store commits on the edge leaving RESP, so a load issued in the very
  // next IDLE cycle already sees it.
  assign do_write = (state == RESP) && !req_q.wen && !err;

  // Per-byte write into the addressed word; unmasked lanes keep their value.
  always_ff @(posedge CLK) begin
    if (do_write) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (mask[i]) mem[word_idx][i*VEC_W +: VEC_W] <= wdata[i*VEC_W +: VEC_W];
      end
    end
  end

  // Outputs decode from registered state, so reset clears them at once.
  always_comb begin
    D_MEM_READY = (state == RESP);
    D_MEM_BUSY  = (state != IDLE);
    D_MEM_ERR   = D_MEM_READY && err;
    D_MEM_DI    = (D_MEM_READY && req_q.wen && !err) ? rdata : 32'd0;
  end

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk, rst_n;
  logic        csn, csn0, csn5, wen;
  logic [3:0]  be;
  logic [11:0] addr;
  logic [31:0] dout;
  logic [31:0] di, di0, di5;
  logic        rdy, err, bsy, rdy0, err0, bsy0, rdy5, err5, bsy5;

  int ncmp = 0;
  int nfail = 0;

  logic [7:0] mref [0:4095];

  dmem_responder #(.ADDR_WIDTH(12), .LATENCY(LAT)) dut (
    .CLK(clk), .RSTn(rst_n), .D_MEM_CSN(csn), .D_MEM_WEN(wen), .D_MEM_BE(be),
    .D_MEM_ADDR(addr), .D_MEM_DOUT(dout), .D_MEM_DI(di), .D_MEM_READY(rdy),
    .D_MEM_ERR(err), .D_MEM_BUSY(bsy));

  dmem_responder #(.ADDR_WIDTH(12), .LATENCY(0)) dut0 (
    .CLK(clk), .RSTn(rst_n), .D_MEM_CSN(csn0), .D_MEM_WEN(wen), .D_MEM_BE(be),
    .D_MEM_ADDR(addr), .D_MEM_DOUT(dout), .D_MEM_DI(di0), .D_MEM_READY(rdy0),
    .D_MEM_ERR(err0), .D_MEM_BUSY(bsy0));

  dmem_responder #(.ADDR_WIDTH(12), .LATENCY(5)) dut5 (
    .CLK(clk), .RSTn(rst_n), .D_MEM_CSN(csn5), .D_MEM_WEN(wen), .D_MEM_BE(be),
    .D_MEM_ADDR(addr), .D_MEM_DOUT(dout), .D_MEM_DI(di5), .D_MEM_READY(rdy5),
    .D_MEM_ERR(err5), .D_MEM_BUSY(bsy5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model (byte-addressed) ----------------
  function automatic int access_size(input logic [3:0] b);
    case (b)
      4'b0001: return 1;
      4'b0011: return 2;
      4'b1111: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic m_err(input logic [3:0] b, input logic [11:0] a);
    int s;
    s = access_size(b);
    if (s == 0) return 1'b1;
    return (int'(a) % s) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [11:0] a);
    int base;
    logic [31:0] w;
    base = int'(a) - (int'(a) % 4);
    w = {mref[base+3], mref[base+2], mref[base+1], mref[base]};
    return w >> (8 * (int'(a) % 4));
  endfunction

  task automatic m_store(input logic [3:0] b, input logic [11:0] a, input logic [31:0] d);
    for (int i = 0; i < access_size(b); i++) mref[int'(a) + i] = d[8*i +: 8];
  endtask

  function automatic logic [42:0] expect_rsp(input logic w, input logic [3:0] b, input logic [11:0] a);
    logic e;
    logic [31:0] d;
    e = m_err(b, a);
    d = (w && !e) ? m_load(a) : 32'd0;
    return {8'(LAT + 1), 1'b1, 1'b1, e, d};
  endfunction

  // Drives one request on the main DUT and reports {latency, busy seen
  // after capture, single-cycle READY, ERR, DI}. Inputs are scrambled
  // after capture since the DUT must ignore them.
  task automatic issue(input logic w, input logic [3:0] b, input logic [11:0] a,
                       input logic [31:0] d, output logic [42:0] obs);
    int lat;
    logic busy_ok, pulse1, e;
    logic [31:0] q;
    @(negedge clk);
    csn = 1'b0; wen = w; be = b; addr = a; dout = d;
    @(negedge clk);
    csn = 1'b1; wen = 1'($urandom); be = 4'($urandom); addr = 12'($urandom); dout = $urandom;
    busy_ok = (bsy === 1'b1);
    lat = 0; e = 1'b0; q = 32'd0; pulse1 = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (rdy === 1'b1) begin
        lat = k + 1; e = err; q = di;
        break;
      end
      @(negedge clk);
    end
    if (lat > 0) begin
      @(negedge clk);
      pulse1 = (rdy === 1'b0) && (bsy === 1'b0) && (di === 32'd0) && (err === 1'b0);
    end
    obs = {8'(lat), busy_ok, pulse1, e, q};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0; csn = 1'b1; csn0 = 1'b1; csn5 = 1'b1;
    wen = 1'b1; be = 4'b0000; addr = '0; dout = '0;
    repeat (3) @(negedge clk);
    ncmp++;
    if ({rdy, err, bsy} !== 3'b000) begin
      nfail++; $display("FAIL reset_flags: got %b want 000", {rdy, err, bsy});
    end
    ncmp++;
    if (di !== 32'd0) begin
      nfail++; $display("FAIL reset_di: got %h want 00000000", di);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sw_lw;
    logic [42:0] obs, ex;
    ex = expect_rsp(1'b0, 4'b1111, 12'h010);
    issue(1'b0, 4'b1111, 12'h010, 32'hDEADBEEF, obs);
    m_store(4'b1111, 12'h010, 32'hDEADBEEF);
    ncmp++;
    if (obs !== ex) begin nfail++; $display("FAIL sw: got %h want %h", obs, ex); end
    ex = expect_rsp(1'b1, 4'b1111, 12'h010);
    issue(1'b1, 4'b1111, 12'h010, 32'h0, obs);
    ncmp++;
    if (obs !== ex) begin nfail++; $display("FAIL lw: got %h want %h", obs, ex); end
    ncmp++;
    if (obs[31:0] !== 32'hDEADBEEF) begin
      nfail++; $display("FAIL lw_data: got %h want deadbeef", obs[31:0]);
    end
  endtask

  task automatic test_sb_lanes;
    logic [42:0] obs, ex;
    logic [31:0] r;
    issue(1'b0, 4'b1111, 12'h020, 32'h11223344, obs);
    m_store(4'b1111, 12'h020, 32'h11223344);
    r = $urandom;
    issue(1'b0, 4'b0001, 12'h021, {r[31:8], 8'hAA}, obs);
    m_store(4'b0001, 12'h021, {r[31:8], 8'hAA});
    ex = expect_rsp(1'b0, 4'b0001, 12'h021);
    ncmp++;
    if (obs !== ex) begin nfail++; $display("FAIL sb1: got %h want %h", obs, ex); end
    r = $urandom;
    issue(1'b0, 4'b0001, 12'h023, {r[31:8], 8'h55}, obs);
    m_store(4'b0001, 12'h023, {r[31:8], 8'h55});
    ex = expect_rsp(1'b1, 4'b1111, 12'h020);
    issue(1'b1, 4'b1111, 12'h020, 32'h0, obs);
    ncmp++;
    if (obs !== ex) begin nfail++; $display("FAIL sb_lw: got %h want %h", obs, ex); end
    ncmp++;
    if (obs[31:0] !== 32'h5522AA44) begin
      nfail++; $display("FAIL sb_word: got %h want 5522aa44", obs[31:0]);
    end
  endtask

  task automatic test_sh_offset;
    logic [42:0] obs, ex;
    issue(1'b0, 4'b1111, 12'h030, 32'h01020304, obs);
    m_store(4'b1111, 12'h030, 32'h01020304);
    issue(1'b0, 4'b0011, 12'h032, 32'hFFFFBEEF, obs);
    m_store(4'b0011, 12'h032, 32'hFFFFBEEF);
    ex = expect_rsp(1'b1, 4'b0011, 12'h032);
    issue(1'b1, 4'b0011, 12'h032, 32'h0, obs);
    ncmp++;
    if (obs !== ex) begin nfail++; $display("FAIL sh_lh: got %h want %h", obs, ex); end
    ncmp++;
    if (obs[15:0] !== 16'hBEEF) begin
      nfail++; $display("FAIL sh_half: got %h want beef", obs[15:0]);
    end
  endtask

  task automatic test_misaligned;
    logic [42:0] obs, ex;
    issue(1'b0, 4'b1111, 12'h000, 32'h5A5A0F0F, obs);
    m_store(4'b1111, 12'h000, 32'h5A5A0F0F);
    issue(1'b0, 4'b1111, 12'h004, 32'hA5A5A5A5, obs);
    m_store(4'b1111, 12'h004, 32'hA5A5A5A5);
    ex = expect_rsp(1'b0, 4'b1111, 12'h005);
    issue(1'b0, 4'b1111, 12'h005, 32'h13579BDF, obs);
    ncmp++;
    if (obs !== ex || obs[32] !== 1'b1) begin
      nfail++; $display("FAIL misaligned_sw: got %h want %h", obs, ex);
    end
    ex = expect_rsp(1'b0, 4'b0011, 12'h003);
    issue(1'b0, 4'b0011, 12'h003, 32'h0000CCCC, obs);
    ncmp++;
    if (obs !== ex || obs[32] !== 1'b1) begin
      nfail++; $display("FAIL misaligned_sh: got %h want %h", obs, ex);
    end
    ex = expect_rsp(1'b1, 4'b1111, 12'h004);
    issue(1'b1, 4'b1111, 12'h004, 32'h0, obs);
    ncmp++;
    if (obs !== ex) begin nfail++; $display("FAIL misaligned_lw4: got %h want %h", obs, ex); end
    ex = expect_rsp(1'b1, 4'b1111, 12'h000);
    issue(1'b1, 4'b1111, 12'h000, 32'h0, obs);
    ncmp++;
    if (obs !== ex) begin nfail++; $display("FAIL misaligned_lw0: got %h want %h", obs, ex); end
    ex = expect_rsp(1'b1, 4'b0101, 12'h004);
    issue(1'b1, 4'b0101, 12'h004, 32'h0, obs);
    ncmp++;
    if (obs !== ex || obs[32] !== 1'b1) begin
      nfail++; $display("FAIL illegal_be: got %h want %h", obs, ex);
    end
  endtask

  // CSN held low: READY lands at cycle k where k mod (L+2) == L, and BUSY is
  // low only in the single IDLE cycle of each period.
  task automatic test_back_to_back;
    int bad0, bad5, n0, n5;
    bad0 = 0; bad5 = 0; n0 = 0; n5 = 0;
    @(negedge clk);
    csn0 = 1'b0; csn5 = 1'b0; wen = 1'b0; be = 4'b1111; addr = 12'h200; dout = $urandom;
    for (int k = 0; k < 28; k++) begin
      @(negedge clk);
      if (k < 8) begin
        if (rdy0 !== 1'(k % 2 == 0) || bsy0 !== 1'(k % 2 != 1)) bad0++;
        if (rdy0 === 1'b1) n0++;
      end
      if (k == 7) csn0 = 1'b1;
      if (rdy5 !== 1'(k % 7 == 5) || bsy5 !== 1'(k % 7 != 6)) bad5++;
      if (rdy5 === 1'b1) n5++;
      if (k == 27) csn5 = 1'b1;
    end
    ncmp++;
    if (bad0 != 0 || n0 != 4) begin
      nfail++; $display("FAIL b2b_lat0: got %0d bad cycles, %0d pulses want 0, 4", bad0, n0);
    end
    ncmp++;
    if (bad5 != 0 || n5 != 4) begin
      nfail++; $display("FAIL b2b_lat5: got %0d bad cycles, %0d pulses want 0, 4", bad5, n5);
    end
    repeat (4) @(negedge clk);
    ncmp++;
    if ({rdy0, bsy0, rdy5, bsy5} !== 4'b0000) begin
      nfail++; $display("FAIL b2b_stop: got %b want 0000", {rdy0, bsy0, rdy5, bsy5});
    end
  endtask

  task automatic test_reset_mid_store;
    logic [42:0] obs, ex;
    logic seen;
    issue(1'b0, 4'b1111, 12'h040, 32'hCAFEF00D, obs);
    m_store(4'b1111, 12'h040, 32'hCAFEF00D);
    @(negedge clk);
    csn = 1'b0; wen = 1'b0; be = 4'b1111; addr = 12'h040; dout = 32'h12345678;
    @(negedge clk);
    csn = 1'b1;
    ncmp++;
    if (bsy !== 1'b1) begin nfail++; $display("FAIL rst_busy_pre: got %b want 1", bsy); end
    #1 rst_n = 1'b0;
    #1;
    ncmp++;
    if ({rdy, err, bsy} !== 3'b000 || di !== 32'd0) begin
      nfail++; $display("FAIL rst_async: got %b/%h want 000/00000000", {rdy, err, bsy}, di);
    end
    seen = 1'b0;
    repeat (3) begin @(negedge clk); if (rdy !== 1'b0) seen = 1'b1; end
    rst_n = 1'b1;
    repeat (6) begin @(negedge clk); if (rdy !== 1'b0) seen = 1'b1; end
    ncmp++;
    if (seen !== 1'b0) begin nfail++; $display("FAIL rst_no_ready: got %b want 0", seen); end
    ex = expect_rsp(1'b1, 4'b1111, 12'h040);
    issue(1'b1, 4'b1111, 12'h040, 32'h0, obs);
    ncmp++;
    if (obs !== ex) begin nfail++; $display("FAIL rst_lw: got %h want %h", obs, ex); end
  endtask

  task automatic test_random;
    logic [42:0] obs, ex;
    logic [3:0]  b;
    logic [11:0] a;
    logic [31:0] d;
    logic        w;
    int          sel, bad;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      issue(1'b0, 4'b1111, 12'(12'h100 + 4*i), d, obs);
      m_store(4'b1111, 12'(12'h100 + 4*i), d);
    end
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0, 1:    b = 4'b0001;
        2, 3:    b = 4'b0011;
        4, 5:    b = 4'b1111;
        default: b = 4'($urandom);
      endcase
      a = 12'(12'h100 + $urandom_range(0, 63));
      w = 1'($urandom);
      d = $urandom;
      ex = expect_rsp(w, b, a);
      issue(w, b, a, d, obs);
      if (!w && !m_err(b, a)) m_store(b, a, d);
      ncmp++;
      if (obs !== ex) begin
        nfail++; bad++;
        if (bad <= 5) $display("FAIL random[%0d] w=%b be=%b a=%h: got %h want %h", i, w, b, a, obs, ex);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sw_lw();
    test_sb_lanes();
    test_sh_offset();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_store();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
